// File: rtl/adder32_arbiter_if.sv
// Requester/response bundle for the shared 32-bit adder arbiter.
// The master side holds the requesters and the response consumer.
// The slave side is the arbiter itself.
interface adder32_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*32-1:0] req_a;
   logic [NUM_REQ*32-1:0] req_b;
   logic [NUM_REQ-1:0]    req_ready;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [31:0]           rsp_sum;
   logic [ID_W-1:0]       rsp_id;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_sum, rsp_id
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_sum, rsp_id
   );
endinterface

// File: rtl/adder32_arbiter.sv
// Round-robin sharing of one registered 32-bit adder between NUM_REQ requesters.
// The response carries the sum together with the index of the requester that owns it.
// The response is held stable while the consumer stalls.
//
// There is no FSM. The only control state is rsp_valid_q and the round-robin pointer.

module adder32_sync (
   input  logic        clk,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] sum_o
);
   logic [31:0] sum_q;

   // Registered add; the carry-out is discarded.
   always_ff @(posedge clk) begin
      sum_q <= a_i + b_i;
   end

   assign sum_o = sum_q;
endmodule

module adder32_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic             clk,
   input  logic             reset_n,
   adder32_arbiter_if.slave bus
);
   localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
   localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

   logic              rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [31:0]       a_q, a_d, b_q, b_d;

   logic              advance;
   logic              accept;
   logic              win_found;
   logic [ID_W-1:0]   win_id;
   logic [ID_W:0]     scan_sum;
   logic [ID_W-1:0]   scan_id;
   logic [31:0]       win_a, win_b;
   logic [31:0]       add_a, add_b;
   logic [31:0]       sum;

   assign advance = !rsp_valid_q | bus.rsp_ready;

   // Pick the first valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      scan_sum  = '0;
      scan_id   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         if (scan_sum >= NUM_REQ_W) begin
            scan_sum = scan_sum - NUM_REQ_W;
         end
         scan_id = scan_sum[ID_W-1:0];
         if (!win_found && bus.req_valid[scan_id]) begin
            win_found = 1'b1;
            win_id    = scan_id;
         end
      end
   end

   // The grant depends only on valid, rsp_ready and state. The operands never feed it.
   assign accept = advance & win_found & reset_n;

   // Build the one-hot grant and mux out the winner's operands.
   always_comb begin
      bus.req_ready = '0;
      win_a         = '0;
      win_b         = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_id == ID_W'(i)) begin
            bus.req_ready[i] = accept;
            win_a            = bus.req_a[i*32 +: 32];
            win_b            = bus.req_b[i*32 +: 32];
         end
      end
   end

   // Adder inputs. A stalled response recomputes from the held operands, so it stays bit-identical.
   always_comb begin
      add_a = a_q;
      add_b = b_q;
      if (!reset_n) begin
         add_a = '0;
         add_b = '0;
      end else if (accept) begin
         add_a = win_a;
         add_b = win_b;
      end
   end

   // Next state for the response tag, the held operands and the pointer.
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rr_ptr_d    = rr_ptr_q;
      a_d         = a_q;
      b_d         = b_q;
      if (accept) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = win_id;
         rr_ptr_d    = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
         a_d         = win_a;
         b_d         = win_b;
      end else if (bus.rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   // State registers; a synchronous reset drops any in-flight response.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rr_ptr_q    <= '0;
         a_q         <= '0;
         b_q         <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rr_ptr_q    <= rr_ptr_d;
         a_q         <= a_d;
         b_q         <= b_d;
      end
   end

   adder32_sync u_adder (
      .clk   (clk),
      .a_i   (add_a),
      .b_i   (add_b),
      .sum_o (sum)
   );

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_sum   = sum;
endmodule

// File: tb/tb_adder32_arbiter.sv
// Directed and random checks for adder32_arbiter with four requesters.
module tb_adder32_arbiter;
   localparam int NR = 4;

   logic clk = 1'b0;
   logic reset_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   adder32_arbiter_if #(.NUM_REQ(NR)) bus ();

   adder32_arbiter #(.NUM_REQ(NR)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_lane(input int i, input logic [31:0] a, input logic [31:0] b);
      bus.req_a[i*32 +: 32] = a;
      bus.req_b[i*32 +: 32] = b;
   endtask

   task automatic do_reset();
      reset_n       = 1'b0;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n       = 1'b0;
      bus.req_valid = '1;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < NR; i++) set_lane(i, 32'h1234_0000 + i, 32'h55);
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
         #1;
         n_checks++;
         if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
         tick();
      end
      reset_n       = 1'b1;
      bus.req_valid = '0;
      n_checks++;
      if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
      n_checks++;
      if (bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id got=%0d exp=0", bus.rsp_id); end
      n_checks++;
      if (bus.rsp_sum !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_sum got=%h exp=00000000", bus.rsp_sum); end
      tick();
      n_checks++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_sum !== 32'h0) begin
         n_fail++; $display("FAIL post_reset_idle got valid=%b sum=%h exp valid=0 sum=00000000", bus.rsp_valid, bus.rsp_sum);
      end
   endtask

   task automatic test_single_add();
      bus.req_valid = 4'b0100;
      bus.rsp_ready = 1'b1;
      set_lane(2, 32'h5, 32'h7);
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant got=%b exp=0100", bus.req_ready); end
      tick();
      set_lane(2, 32'hFFFF_FFFF, 32'h1);
      #1;
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 32'hC || bus.rsp_id !== 2'd2) begin
         n_fail++; $display("FAIL single_rsp got v=%b sum=%h id=%0d exp v=1 sum=0000000c id=2", bus.rsp_valid, bus.rsp_sum, bus.rsp_id);
      end
      n_checks++;
      if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL wrap_grant got=%b exp=0100", bus.req_ready); end
      tick();
      bus.req_valid = '0;
      #1;
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 32'h0 || bus.rsp_id !== 2'd2) begin
         n_fail++; $display("FAIL wrap_rsp got v=%b sum=%h id=%0d exp v=1 sum=00000000 id=2", bus.rsp_valid, bus.rsp_sum, bus.rsp_id);
      end
      tick();
      n_checks++;
      if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_drain got=%b exp=0", bus.rsp_valid); end
   endtask

   task automatic test_round_robin();
      int ord[5] = '{0, 1, 2, 3, 0};
      logic [3:0] exp_rdy;
      do_reset();
      for (int i = 0; i < NR; i++) set_lane(i, 32'(256 * (i + 1)), 32'(i));
      bus.req_valid = 4'b1111;
      bus.rsp_ready = 1'b1;
      for (int s = 0; s < 5; s++) begin
         #1;
         exp_rdy = 4'(1 << ord[s]);
         n_checks++;
         if (bus.req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_grant_%0d got=%b exp=%b", s, bus.req_ready, exp_rdy); end
         if (s > 0) begin
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(ord[s-1]) || bus.rsp_sum !== 32'(256 * (ord[s-1] + 1) + ord[s-1])) begin
               n_fail++; $display("FAIL rr_rsp_%0d got v=%b id=%0d sum=%h exp id=%0d", s, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, ord[s-1]);
            end
         end
         tick();
      end
      bus.req_valid = 4'b0010;
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL rr_to2 got=%b exp=0010", bus.req_ready); end
      tick();
      bus.req_valid = 4'b1010;
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL rr_sparse_3 got=%b exp=1000", bus.req_ready); end
      n_checks++;
      if (bus.rsp_id !== 2'd1 || bus.rsp_sum !== 32'h201) begin n_fail++; $display("FAIL rr_sparse_rsp1 got id=%0d sum=%h exp id=1 sum=00000201", bus.rsp_id, bus.rsp_sum); end
      tick();
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL rr_sparse_1 got=%b exp=0010", bus.req_ready); end
      n_checks++;
      if (bus.rsp_id !== 2'd3 || bus.rsp_sum !== 32'h403) begin n_fail++; $display("FAIL rr_sparse_rsp3 got id=%0d sum=%h exp id=3 sum=00000403", bus.rsp_id, bus.rsp_sum); end
      tick();
      bus.req_valid = '0;
      #1;
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_sum !== 32'h201) begin
         n_fail++; $display("FAIL rr_last_rsp got v=%b id=%0d sum=%h exp v=1 id=1 sum=00000201", bus.rsp_valid, bus.rsp_id, bus.rsp_sum);
      end
      tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      bus.req_valid = 4'b0001;
      bus.rsp_ready = 1'b1;
      set_lane(0, 32'h10, 32'h20);
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_grant0 got=%b exp=0001", bus.req_ready); end
      tick();
      bus.req_valid = 4'b0010;
      bus.rsp_ready = 1'b0;
      set_lane(1, 32'h3, 32'h4);
      for (int c = 0; c < 3; c++) begin
         set_lane(0, 32'hDEAD_0000 + c, 32'hBEEF);
         #1;
         n_checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 32'h30 || bus.rsp_id !== 2'd0) begin
            n_fail++; $display("FAIL bp_hold_%0d got v=%b sum=%h id=%0d exp v=1 sum=00000030 id=0", c, bus.rsp_valid, bus.rsp_sum, bus.rsp_id);
         end
         n_checks++;
         if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready_%0d got=%b exp=0000", c, bus.req_ready); end
         tick();
      end
      bus.rsp_ready = 1'b1;
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_grant got=%b exp=0010", bus.req_ready); end
      n_checks++;
      if (bus.rsp_sum !== 32'h30) begin n_fail++; $display("FAIL bp_release_sum got=%h exp=00000030", bus.rsp_sum); end
      tick();
      bus.req_valid = '0;
      #1;
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 32'h7 || bus.rsp_id !== 2'd1) begin
         n_fail++; $display("FAIL bp_next_rsp got v=%b sum=%h id=%0d exp v=1 sum=00000007 id=1", bus.rsp_valid, bus.rsp_sum, bus.rsp_id);
      end
      tick();
   endtask

   task automatic test_reset_mid_stall();
      // Pointer is at 2 here, so with 0 and 3 valid only a pointer reset makes 0 win.
      bus.req_valid = 4'b0010;
      bus.rsp_ready = 1'b1;
      set_lane(1, 32'h11, 32'h22);
      tick();
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'b1001;
      #1;
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 4'b0000) begin
         n_fail++; $display("FAIL mid_stall_setup got v=%b rdy=%b exp v=1 rdy=0000", bus.rsp_valid, bus.req_ready);
      end
      tick();
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_ready got=%b exp=0000", bus.req_ready); end
      tick();
      reset_n = 1'b1;
      #1;
      n_checks++;
      if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_drop got=%b exp=0", bus.rsp_valid); end
      n_checks++;
      if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_reset_grant got=%b exp=0001", bus.req_ready); end
      tick();
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      #1;
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL mid_reset_rsp got v=%b id=%0d exp v=1 id=0", bus.rsp_valid, bus.rsp_id); end
      tick();
   endtask

   task automatic test_random();
      logic [31:0] q_sum[$];
      int          q_id[$];
      int          m_ptr;
      int          exp_id;
      int          idx;
      int          waits[NR];
      logic        m_valid, adv;
      logic [3:0]  exp_rdy;
      do_reset();
      m_ptr = 0;
      for (int i = 0; i < NR; i++) waits[i] = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         bus.req_valid = 4'($urandom_range(0, 15));
         for (int i = 0; i < NR; i++) set_lane(i, $urandom, $urandom);
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         m_valid = (q_sum.size() != 0);
         adv     = !m_valid || bus.rsp_ready;
         exp_id  = -1;
         for (int k = 0; k < NR; k++) begin
            idx = (m_ptr + k) % NR;
            if (exp_id < 0 && bus.req_valid[idx]) exp_id = idx;
         end
         exp_rdy = (adv && exp_id >= 0) ? 4'(1 << exp_id) : 4'b0000;
         n_checks++;
         if (bus.req_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_rdy); end
         n_checks++;
         if (bus.rsp_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, m_valid); end
         if (m_valid) begin
            n_checks++;
            if (bus.rsp_sum !== q_sum[0] || bus.rsp_id !== 2'(q_id[0])) begin
               n_fail++; $display("FAIL rnd_rsp cyc=%0d got sum=%h id=%0d exp sum=%h id=%0d", cyc, bus.rsp_sum, bus.rsp_id, q_sum[0], q_id[0]);
            end
            if (bus.rsp_ready) begin
               void'(q_sum.pop_front());
               void'(q_id.pop_front());
            end
         end
         if (adv && exp_id >= 0) begin
            q_sum.push_back(bus.req_a[exp_id*32 +: 32] + bus.req_b[exp_id*32 +: 32]);
            q_id.push_back(exp_id);
            m_ptr = (exp_id + 1) % NR;
            for (int i = 0; i < NR; i++) begin
               if (i == exp_id || !bus.req_valid[i]) begin
                  waits[i] = 0;
               end else begin
                  waits[i]++;
                  n_checks++;
                  if (waits[i] >= NR) begin n_fail++; $display("FAIL rnd_starve cyc=%0d req=%0d waited=%0d accepts", cyc, i, waits[i]); end
               end
            end
         end else begin
            for (int i = 0; i < NR; i++) if (!bus.req_valid[i]) waits[i] = 0;
         end
         tick();
      end
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      #1;
      if (q_sum.size() != 0) begin
         n_checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== q_sum[0] || bus.rsp_id !== 2'(q_id[0])) begin
            n_fail++; $display("FAIL rnd_final_rsp got v=%b sum=%h id=%0d exp sum=%h id=%0d", bus.rsp_valid, bus.rsp_sum, bus.rsp_id, q_sum[0], q_id[0]);
         end
         void'(q_sum.pop_front());
         void'(q_id.pop_front());
      end
      tick();
      n_checks++;
      if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_drain got=%b exp=0", bus.rsp_valid); end
   endtask

   initial begin
      reset_n       = 1'b0;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b1;
      test_reset();
      test_single_add();
      test_round_robin();
      test_backpressure();
      test_reset_mid_stall();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/adder32_arbiter.md
# adder32_arbiter

Round-robin arbiter and sequencer that shares one clocked 32-bit adder (`adder32_sync`) between `NUM_REQ` requesters, such as PC increment, branch-target and address-generation units. It accepts at most one add per cycle and drives the chosen operands into the adder. It returns the registered sum one cycle later, tagged with the requester index. The result is held stable under response backpressure.

## Interface

- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester index.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `reset_n`, input, 1: reset, synchronous, active-low.
- `req_valid`, input, `NUM_REQ`: bit i set means requester i has an operand pair pending.
- `req_a`, input, `NUM_REQ*32`: operand A; requester i uses bits [32i+31:32i].
- `req_b`, input, `NUM_REQ*32`: operand B, packed the same way as `req_a`.
- `req_ready`, output, `NUM_REQ`: grant, combinational and one-hot or zero; the transfer happens when `req_valid[i] & req_ready[i]`.
- `rsp_valid`, output, 1: `rsp_sum` and `rsp_id` are valid.
- `rsp_ready`, input, 1: the consumer accepts the response.
- `rsp_sum`, output, 32: (A + B) mod 2^32.
- `rsp_id`, output, `ID_W`: index of the requester that owns `rsp_sum`.

## Operation

- **Instantiation:** one `adder32_sync` instance. No other adder is present in the block.
- **Advance condition:** `advance = !rsp_valid | rsp_ready`. When `advance` is 0, no grant is issued.
- **Winner selection:** scan `req_valid` starting at `rr_ptr` and moving upward modulo `NUM_REQ`. The first set bit wins. `req_ready[winner] = advance`; all other `req_ready` bits are 0.
  - `req_ready` does not depend on `req_a` or `req_b`.
  - `req_ready` may depend on `req_valid`.
- **On accept from requester i:**
  - `a_q` and `b_q` capture the operands.
  - `rsp_id` captures i.
  - `rsp_valid` is set to 1.
  - `rr_ptr` becomes (i+1) mod `NUM_REQ`.
- **Adder operand mux:**
  - On accept: the winner's operands.
  - Otherwise: `a_q`/`b_q`, so a stalled result is recomputed and stays bit-identical.
  - While `reset_n` is 0: zero.
- **`rsp_valid` next state:**
  - 1 on accept.
  - 0 if `rsp_ready` is 1 and there is no accept.
  - Otherwise held.
- **`rr_ptr` and fairness:** `rr_ptr` is unchanged when nothing is accepted. Any requester holding `req_valid` is granted within `NUM_REQ` accepts; there is no starvation.
- **Arithmetic:** carry-out is discarded. 0xFFFFFFFF + 1 = 0x00000000. No overflow flag.
- **Reset** (`reset_n` low at a rising edge):
  - `rsp_valid` = 0, `rsp_id` = 0, `rr_ptr` = 0, `a_q` = `b_q` = 0.
  - Adder inputs are forced to 0, so `rsp_sum` = 0 from the first cycle after reset.
  - During reset, `req_ready` = 0.
  - Reset mid-operation drops any in-flight or stalled response without delivering it.

## Timing

- **Latency:** accept in cycle N gives `rsp_valid` = 1 in cycle N+1 with the sum of cycle N's operands.
- **Throughput:** one add per cycle while `rsp_ready` stays high.
- **Response handshake:** the response completes in the cycle with `rsp_valid & rsp_ready`. A new accept in that same cycle is legal, giving back-to-back responses with no bubble.
- **Stall:** while `rsp_valid & !rsp_ready`, `rsp_sum` and `rsp_id` are held constant and every `req_ready` bit is 0.
- **Combinational paths:** `req_valid` and `rsp_ready` to `req_ready`. No combinational path from `req_a`/`req_b` to any output.
- **Simultaneous requests:** resolved only by `rr_ptr`; a lower index has no fixed priority.

## Test plan

- **Reset values:** hold `reset_n` = 0 for 2 cycles with all `req_valid` set. Required: `req_ready` = 0. After release: `rsp_valid` = 0, `rsp_id` = 0, `rsp_sum` = 0x00000000.
- **Single add and wrap:** requester 2 sends A = 0x00000005, B = 0x00000007 with `rsp_ready` = 1. Required: one cycle later `rsp_valid` = 1, `rsp_sum` = 0x0000000C, `rsp_id` = 2. Then A = 0xFFFFFFFF, B = 0x00000001. Required: `rsp_sum` = 0x00000000.
- **Round-robin order:** all four `req_valid` held high with `rsp_ready` = 1. Required: grants in order 0, 1, 2, 3, 0; responses arrive back-to-back on consecutive cycles with matching `rsp_id`. Then only requesters 1 and 3 valid after the pointer reaches 2. Required: grant 3, then 1.
- **Backpressure:** accept from requester 0 with A = 0x10, B = 0x20, then hold `rsp_ready` = 0 for 3 cycles while requester 1 is valid. Required: `rsp_sum` holds 0x30 and `rsp_id` holds 0; `req_ready` = 0 throughout. When `rsp_ready` rises, requester 1 is granted in that same cycle.
- **Reset mid-stall:** drive a stalled response, then assert `reset_n` = 0 for 1 cycle. Required: `rsp_valid` = 0 afterward and the next grant goes to requester 0 if it is valid.
- **Random:** 10k cycles of random `req_valid`, operands and `rsp_ready`. A scoreboard checks every response against A + B and the requester index, checks that no response is lost or duplicated, and checks that no requester waits more than `NUM_REQ` accepts.
